servo_ramp_ctrl: RTL

- Sequences the servo pulse-width datapath.
- Accepts target pulse widths (in clk_in cycles) over a valid/ready handshake.
- Clamps each target to the servo's legal range, then slews the live width toward it by at most STEP_CYC per 20 ms frame.
- Generates the PWM output itself, so width changes only take effect at frame boundaries and never glitch mid-pulse. Sits between the angle-select logic and the servo pin.

---
 rtl/servo_ramp_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/servo_ramp_ctrl.sv
// Clamps commanded servo widths, slews toward them once per frame, drives PWM.
// Optional SERVO_PRESET_EN adds a switch-driven MID/MIN preset command.
module servo_ramp_ctrl #(
  parameter int FRAME_CYC = 500000,
  parameter int MIN_CYC   = 12500,
  parameter int MAX_CYC   = 60000,
  parameter int STEP_CYC  = 250,
  parameter int MID_CYC   = 30000
) (
  input  logic        clk_in,
  input  logic        rst,
`ifdef SERVO_PRESET_EN
  input  logic        switch,
`endif
  input  logic        cmd_valid,
  input  logic [19:0] cmd_width,
  output logic        cmd_ready,
  output logic [19:0] cur_width,
  output logic        pwm_out,
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [19:0] FLAST = 20'(FRAME_CYC - 1);
  localparam logic [19:0] MINW  = 20'(MIN_CYC);
  localparam logic [19:0] MAXW  = 20'(MAX_CYC);
  localparam logic [19:0] STEPW = 20'(STEP_CYC);

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [19:0] frame_cnt;
  logic [19:0] target;
  logic [19:0] target_nx;
  logic [19:0] cur_nx;
  logic [19:0] clamped;
  logic [19:0] diff;
  logic [19:0] step_w;
  logic [19:0] stepped;
  logic [19:0] ld_width;
  logic        ld_valid;
  logic        xfer;
  logic        go_up;

  assign frame_tick = (frame_cnt == FLAST);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == RAMP);
  assign xfer       = cmd_valid && cmd_ready;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      frame_cnt <= '0;
      pwm_out   <= 1'b0;
    end else begin
      frame_cnt <= frame_tick ? '0 : frame_cnt + 20'd1;
      pwm_out   <= (frame_cnt < cur_width);
    end
  end

  always_comb begin
    clamped = cmd_width;
    unique case (1'b1)
      (cmd_width < MINW): clamped = MINW;
      (cmd_width > MAXW): clamped = MAXW;
      default:            clamped = cmd_width;
    endcase
  end

  // Difference taken only in its non-negative direction, so no wrap.
  always_comb begin
    go_up   = (cur_width < target);
    diff    = go_up ? (target - cur_width)
                    : (cur_width - target);
    step_w  = (diff < STEPW) ? diff : STEPW;
    stepped = go_up ? (cur_width + step_w)
                    : (cur_width - step_w);
  end

`ifdef SERVO_PRESET_EN
  localparam logic [19:0] MIDW = 20'(MID_CYC);

  logic sw_s1;
  logic sw_s2;
  logic sw_prev;
  logic pend;
  logic pre_req;
  logic pre_go;

  assign pre_req = pend || (sw_s2 != sw_prev);
  assign pre_go  = pre_req && cmd_ready && !xfer;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sw_s1   <= 1'b0;
      sw_s2   <= 1'b0;
      sw_prev <= 1'b0;
      pend    <= 1'b0;
    end else begin
      sw_s1   <= switch;
      sw_s2   <= sw_s1;
      sw_prev <= sw_s2;
      pend    <= pre_req && !pre_go;
    end
  end

  // External transfer wins; preset waits for a free IDLE cycle.
  assign ld_valid = xfer || pre_go;
  assign ld_width = xfer ? clamped
                  : (sw_s2 ? MIDW : MINW);
`else
  assign ld_valid = xfer;
  assign ld_width = clamped;
`endif

  always_comb begin
    state_nx  = state;
    target_nx = target;
    cur_nx    = cur_width;
    case (state)
      IDLE: begin
        if (ld_valid && (ld_width != cur_width)) begin
          target_nx = ld_width;
          state_nx  = RAMP;
        end
      end
      RAMP: begin
        if (frame_tick) begin
          cur_nx = stepped;
          if (stepped == target) begin
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      target    <= MINW;
      cur_width <= MINW;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      cur_width <= cur_nx;
    end
  end

endmodule
